fp16_div_iterative: RTL and testbench
=====================================

# fp16_div_iterative

Sequential IEEE half-precision divider computing `a / b`, the inverse operation of the team's combinational FP16 multiplier and sharing its bit layout. It uses one restoring-division step per cycle to limit area next to the multiplier array. A valid/ready handshake on both sides lets it sit in the same datapath slot as the multiplier, with a different latency.

## Interface
- `EXP_W`, default 5: exponent field width.
- `MAN_W`, default 10: stored mantissa width.
- `QBITS`, default `MAN_W+4` (14): quotient bits generated.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, synchronous, active-high.
- `in_valid  in  1`: operands valid.
- `in_ready  out  1`: divider idle and able to accept.
- `a  in  16`: dividend {sign, exp[4:0], man[9:0]}.
- `b  in  16`: divisor, same layout.
- `out_valid  out  1`: result valid.
- `out_ready  in  1`: consumer accepts result.
- `result  out  16`: quotient.
- `flags  out  5`: bit order {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- **FSM states:** IDLE, DIV, ROUND, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, capture sign = `a[15]^b[15]`, the exponents, and significands ma={1,a.man} and mb={1,b.man}.
  - From IDLE, a special case goes to DONE; otherwise go to DIV with remainder=ma, count=0.
- **Flush-to-zero:** exp==0 is treated as signed zero on input. Subnormal results flush to signed zero.
- **Special cases, by priority:**
  - Any NaN input, 0/0, or inf/inf: result 0x7E00, flags invalid.
  - Finite nonzero / 0: result {sign,0x7C00}, flags div_by_zero.
  - inf / finite: result {sign,0x7C00}, flags 0.
  - 0 / nonzero or finite / inf: result {sign,0x0000}, flags 0.
- **DIV:** one quotient bit per cycle, MSB first.
  - If rem ≥ mb: q bit=1, rem=(rem-mb)<<1.
  - Else: q bit=0, rem=rem<<1.
  - Width: rem is 12 bits. Exactly `QBITS` cycles, then ROUND.
- **ROUND:** round-to-nearest-even on q[13:0].
  - If q[13]=1: m=q[13:3], G=q[2], S=|q[1:0] or rem≠0, E=Ea-Eb+15.
  - Else: m=q[12:2], G=q[1], S=q[0] or rem≠0, E=Ea-Eb+14.
  - Round up when G&(S|m[0]). If rounding carries to 2.0, shift right and increment E.
  - Inexact = G|S. E is computed as 7-bit signed.
  - E≥31: result {sign,0x7C00}, flags overflow|inexact.
  - E≤0: result {sign,0}, flags underflow|inexact.
  - Otherwise: result {sign,E[4:0],m[9:0]}.
- **DONE:** `out_valid`=1. `result`/`flags` stay stable until `out_ready`, then return to IDLE.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0. Internal registers are cleared.
- **Reset mid-operation:** reset in any state aborts the operation. The next cycle is IDLE with no output.
- **Normal latency:** accept at edge t; DIV occupies t+1..t+14; ROUND at t+15; `out_valid` high from t+16.
- **Special-case latency:** `out_valid` high at t+1.
- **Throughput:** one operation in flight. `in_ready`=0 outside IDLE.
- **Back-to-back:** the handshake completing in DONE returns to IDLE, so the next accept occurs on the following edge at earliest. No accept/complete overlap.
- **Back-pressure:** `out_ready` held low keeps DONE indefinitely with outputs unchanged.
- **Input changes:** `in_valid`/`a`/`b` changing while busy are ignored.

## Structure
- **Shared package `fp16_pkg`:** EXP_W, MAN_W, BIAS=15, QNAN=16'h7E00, INF=16'h7C00, flag bit indices, state enum type.
- **Sub-module `fp16_div_round`:** combinational normalize/round/pack from {q, rem_nz, sign, Ea, Eb} to {result, flags}, instantiated once in ROUND.
- **Top level:** holds the FSM, special-case decode, and iteration datapath.

## Test plan
- 0x3C00/0x3C00 → 0x3C00, flags 0, `out_valid` exactly 16 cycles after accept. 0x4600/0x4000 → 0x4200, flags 0.
- 0x3C00/0x4200 (1/3) → 0x3555, flags=00001. 0xBC00/0x4200 → 0xB555, flags=00001.
- Special cases, each with `out_valid` at t+1:
  - 0x3C00/0x0000 → 0x7C00, flags=01000.
  - 0x0000/0x0000 → 0x7E00, flags=10000.
  - 0x7C01/0x3C00 → 0x7E00, flags=10000.
  - 0x3C00/0x7C00 → 0x0000, flags 0.
- Range limits:
  - 0x7BFF/0x3800 → 0x7C00, flags=00101.
  - 0x0400/0x4000 → 0x0000, flags=00011.
- Back-pressure and reset:
  - `out_ready` low for 20 cycles: `result` stable, `in_ready`=0.
  - `rst` asserted at DIV cycle 7: next cycle IDLE with `out_valid`=0, and a following 0x4600/0x4000 still yields 0x4200.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 constants, flag bit positions and divider state encoding.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] INF  = 16'h7C00;

    // Bit positions in the 5-bit flags word {invalid, div_by_zero, overflow, underflow, inexact}.
    localparam int FLAG_INVALID = 4;
    localparam int FLAG_DBZ     = 3;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_UNF     = 1;
    localparam int FLAG_INEXACT = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/fp16_div_round.sv
// Normalizes the raw restoring-division quotient, rounds to nearest-even
// and packs the FP16 result with overflow/underflow flush.
module fp16_div_round
    import fp16_pkg::*;
(
    input  logic [MAN_W+3:0]     q_i,
    input  logic                 rem_nz_i,
    input  logic                 sign_i,
    input  logic [EXP_W-1:0]     ea_i,
    input  logic [EXP_W-1:0]     eb_i,
    output logic [EXP_W+MAN_W:0] result_o,
    output logic [4:0]           flags_o
);
    localparam int EW = 7;
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] BIAS_HI = EW'(BIAS);
    localparam logic signed [EW-1:0] BIAS_LO = EW'(BIAS - 1);
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E  = EW'(0);

    logic                  g_s;
    logic                  s_s;
    logic                  inexact_s;
    logic [MAN_W:0]        m_s;
    logic [MAN_W+1:0]      m_rnd_s;
    logic [MAN_W-1:0]      m_fin_s;
    logic signed [EW-1:0]  ediff_s;
    logic signed [EW-1:0]  e_s;
    logic signed [EW-1:0]  e_fin_s;

    assign ediff_s = $signed({{(EW-EXP_W){1'b0}}, ea_i}) - $signed({{(EW-EXP_W){1'b0}}, eb_i});

    // Quotient lies in (0.5, 2): pick the leading-one alignment plus guard and sticky.
    always_comb begin
        if (q_i[MAN_W+3]) begin
            m_s = q_i[MAN_W+3:3];
            g_s = q_i[2];
            s_s = (|q_i[1:0]) | rem_nz_i;
            e_s = ediff_s + BIAS_HI;
        end else begin
            m_s = q_i[MAN_W+2:2];
            g_s = q_i[1];
            s_s = q_i[0] | rem_nz_i;
            e_s = ediff_s + BIAS_LO;
        end
    end

    assign inexact_s = g_s | s_s;
    assign m_rnd_s   = {1'b0, m_s} + {{(MAN_W+1){1'b0}}, g_s & (s_s | m_s[0])};

    // A rounding carry into 2.0 renormalizes by one place.
    always_comb begin
        if (m_rnd_s[MAN_W+1]) begin
            m_fin_s = m_rnd_s[MAN_W:1];
            e_fin_s = e_s + ONE_E;
        end else begin
            m_fin_s = m_rnd_s[MAN_W-1:0];
            e_fin_s = e_s;
        end
    end

    // Range check and pack; subnormal results flush to signed zero.
    always_comb begin
        result_o = {sign_i, e_fin_s[EXP_W-1:0], m_fin_s};
        flags_o  = 5'b00000;
        if (e_fin_s >= EXP_MAX) begin
            result_o               = {sign_i, INF[EXP_W+MAN_W-1:0]};
            flags_o[FLAG_OVF]      = 1'b1;
            flags_o[FLAG_INEXACT]  = 1'b1;
        end else if (e_fin_s <= ZERO_E) begin
            result_o               = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o[FLAG_UNF]      = 1'b1;
            flags_o[FLAG_INEXACT]  = 1'b1;
        end else begin
            flags_o[FLAG_INEXACT]  = inexact_s;
        end
    end

endmodule

// File: rtl/fp16_div_iterative.sv
// Sequential FP16 divider a / b: one restoring-division quotient bit per cycle,
// valid/ready handshake on both sides, flush-to-zero for subnormals.
module fp16_div_iterative #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int QBITS = MAN_W + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);
    import fp16_pkg::*;

    localparam int W     = EXP_W + MAN_W + 1;
    localparam int CNT_W = $clog2(QBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e         state_q;
    logic               sign_q;
    logic [EXP_W-1:0]   ea_q;
    logic [EXP_W-1:0]   eb_q;
    logic [MAN_W:0]     mb_q;
    logic [MAN_W+1:0]   rem_q;
    logic [MAN_W+1:0]   rem_d;
    logic [QBITS-1:0]   quo_q;
    logic [QBITS-1:0]   quo_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [W-1:0]       result_q;
    logic [4:0]         flags_q;

    logic               sign_s;
    logic               a_zero_s, a_inf_s, a_nan_s;
    logic               b_zero_s, b_inf_s, b_nan_s;
    logic               sp_hit_s;
    logic [W-1:0]       sp_result_s;
    logic [4:0]         sp_flags_s;
    logic [MAN_W:0]     diff_s;
    logic               rem_nz_s;
    logic [W-1:0]       rnd_result_s;
    logic [4:0]         rnd_flags_s;

    assign sign_s   = a[W-1] ^ b[W-1];
    assign a_zero_s = ~|a[W-2:MAN_W];
    assign b_zero_s = ~|b[W-2:MAN_W];
    assign a_inf_s  = (&a[W-2:MAN_W]) & ~|a[MAN_W-1:0];
    assign b_inf_s  = (&b[W-2:MAN_W]) & ~|b[MAN_W-1:0];
    assign a_nan_s  = (&a[W-2:MAN_W]) &  |a[MAN_W-1:0];
    assign b_nan_s  = (&b[W-2:MAN_W]) &  |b[MAN_W-1:0];

    // Special-operand decode, highest priority first; inf/0 counts as inf/finite.
    always_comb begin
        sp_hit_s    = 1'b1;
        sp_result_s = {W{1'b0}};
        sp_flags_s  = 5'b00000;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            sp_result_s              = QNAN;
            sp_flags_s[FLAG_INVALID] = 1'b1;
        end else if (a_inf_s) begin
            sp_result_s = {sign_s, INF[W-2:0]};
        end else if (b_zero_s) begin
            sp_result_s          = {sign_s, INF[W-2:0]};
            sp_flags_s[FLAG_DBZ] = 1'b1;
        end else if (a_zero_s || b_inf_s) begin
            sp_result_s = {sign_s, {(W-1){1'b0}}};
        end else begin
            sp_hit_s = 1'b0;
        end
    end

    // rem < 2*mb always holds, so the difference fits in MAN_W+1 bits.
    assign diff_s = rem_q[MAN_W:0] - mb_q;

    // One restoring-division step.
    always_comb begin
        if (rem_q >= {1'b0, mb_q}) begin
            rem_d = {diff_s, 1'b0};
            quo_d = {quo_q[QBITS-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[MAN_W:0], 1'b0};
            quo_d = {quo_q[QBITS-2:0], 1'b0};
        end
    end

    assign rem_nz_s = |rem_q;

    fp16_div_round u_round (
        .q_i      (quo_q),
        .rem_nz_i (rem_nz_s),
        .sign_i   (sign_q),
        .ea_i     (ea_q),
        .eb_i     (eb_q),
        .result_o (rnd_result_s),
        .flags_o  (rnd_flags_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            ea_q        <= {EXP_W{1'b0}};
            eb_q        <= {EXP_W{1'b0}};
            mb_q        <= {(MAN_W+1){1'b0}};
            rem_q       <= {(MAN_W+2){1'b0}};
            quo_q       <= {QBITS{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= {W{1'b0}};
            flags_q     <= 5'b00000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q     <= sign_s;
                        ea_q       <= a[W-2:MAN_W];
                        eb_q       <= b[W-2:MAN_W];
                        mb_q       <= {1'b1, b[MAN_W-1:0]};
                        rem_q      <= {2'b01, a[MAN_W-1:0]};
                        quo_q      <= {QBITS{1'b0}};
                        cnt_q      <= {CNT_W{1'b0}};
                        in_ready_q <= 1'b0;
                        if (sp_hit_s) begin
                            result_q    <= sp_result_s;
                            flags_q     <= sp_flags_s;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    result_q    <= rnd_result_s;
                    flags_q     <= rnd_flags_s;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_div_iterative.sv
// Scoreboard bench for fp16_div_iterative: expected results are queued at issue
// and popped when the divider presents its output.
module tb_fp16_div_iterative;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
    } vec_t;

    vec_t sb_q[$];

    always #5 clk = ~clk;

    fp16_div_iterative dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // All tasks start and end on a falling edge.
    task automatic send(input vec_t v);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
    endtask

    // Cycle 1 is the falling edge right after the accepting edge.
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        n_tests++;
        if (result !== 16'h0000 || flags !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h flags=%b, required 0000 00000", result, flags);
        end
    endtask

    task automatic test_normal();
        vec_t tbl [7];
        vec_t e;
        int   cyc;
        tbl = '{
            '{16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 16},
            '{16'h4600, 16'h4000, 16'h4200, 5'b00000, 16},
            '{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16},
            '{16'hBC00, 16'h4200, 16'hB555, 5'b00001, 16},
            '{16'h3E00, 16'h3C01, 16'h3DFF, 5'b00001, 16},
            '{16'h3C00, 16'h4700, 16'h3092, 5'b00001, 16},
            '{16'hC000, 16'h4000, 16'hBC00, 5'b00000, 16}
        };
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out(cyc);
            e = sb_q.pop_front();
            n_tests++;
            if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
                n_fail++;
                $display("FAIL normal %h/%h: result=%h flags=%b lat=%0d, required %h %b %0d",
                         e.a, e.b, result, flags, cyc, e.res, e.flg, e.lat);
            end
            ack();
        end
    endtask

    task automatic test_special();
        vec_t tbl [9];
        vec_t e;
        int   cyc;
        tbl = '{
            '{16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 1},
            '{16'h0000, 16'h0000, 16'h7E00, 5'b10000, 1},
            '{16'h7C01, 16'h3C00, 16'h7E00, 5'b10000, 1},
            '{16'h3C00, 16'h7C00, 16'h0000, 5'b00000, 1},
            '{16'hBC00, 16'h0000, 16'hFC00, 5'b01000, 1},
            '{16'hFC00, 16'h4000, 16'hFC00, 5'b00000, 1},
            '{16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 1},
            '{16'h0001, 16'h3C00, 16'h0000, 5'b00000, 1},
            '{16'h8000, 16'h3C00, 16'h8000, 5'b00000, 1}
        };
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out(cyc);
            e = sb_q.pop_front();
            n_tests++;
            if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
                n_fail++;
                $display("FAIL special %h/%h: result=%h flags=%b lat=%0d, required %h %b %0d",
                         e.a, e.b, result, flags, cyc, e.res, e.flg, e.lat);
            end
            ack();
        end
    endtask

    task automatic test_range();
        vec_t tbl [3];
        vec_t e;
        int   cyc;
        tbl = '{
            '{16'h7BFF, 16'h3800, 16'h7C00, 5'b00101, 16},
            '{16'hFBFF, 16'h3800, 16'hFC00, 5'b00101, 16},
            '{16'h0400, 16'h4000, 16'h0000, 5'b00011, 16}
        };
        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_out(cyc);
            e = sb_q.pop_front();
            n_tests++;
            if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
                n_fail++;
                $display("FAIL range %h/%h: result=%h flags=%b lat=%0d, required %h %b %0d",
                         e.a, e.b, result, flags, cyc, e.res, e.flg, e.lat);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        vec_t v;
        vec_t e;
        int   cyc;
        v = '{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16};
        send(v);
        wait_out(cyc);
        e = sb_q.pop_front();
        n_tests++;
        if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
            n_fail++;
            $display("FAIL backpressure_first: result=%h flags=%b lat=%0d, required %h %b %0d",
                     result, flags, cyc, e.res, e.flg, e.lat);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a        = 16'h4600;
            b        = 16'h4000;
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== e.res || flags !== e.flg) begin
                n_fail++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b result=%h flags=%b, required 1 0 %h %b",
                         i, out_valid, in_ready, result, flags, e.res, e.flg);
            end
        end
        in_valid = 1'b0;
        ack();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        vec_t v;
        vec_t e;
        int   cyc;
        v = '{16'h4600, 16'h4000, 16'h4200, 5'b00000, 16};
        send(v);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        send(v);
        wait_out(cyc);
        e = sb_q.pop_front();
        n_tests++;
        if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
            n_fail++;
            $display("FAIL reset_mid_next: result=%h flags=%b lat=%0d, required %h %b %0d",
                     result, flags, cyc, e.res, e.flg, e.lat);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        vec_t v1;
        vec_t v2;
        vec_t e;
        int   cyc;
        v1 = '{16'h4000, 16'h3C00, 16'h4000, 5'b00000, 16};
        v2 = '{16'h3C00, 16'h4200, 16'h3555, 5'b00001, 16};
        send(v1);
        wait_out(cyc);
        e = sb_q.pop_front();
        n_tests++;
        if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
            n_fail++;
            $display("FAIL b2b_first: result=%h flags=%b lat=%0d, required %h %b %0d",
                     result, flags, cyc, e.res, e.flg, e.lat);
        end
        a         = v2.a;
        b         = v2.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sb_q.push_back(v2);
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_overlap: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: in_ready=%b, required 0", in_ready);
        end
        wait_out(cyc);
        e = sb_q.pop_front();
        n_tests++;
        if (result !== e.res || flags !== e.flg || cyc != e.lat) begin
            n_fail++;
            $display("FAIL b2b_second: result=%h flags=%b lat=%0d, required %h %b %0d",
                     result, flags, cyc, e.res, e.flg, e.lat);
        end
        ack();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
